// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: in-flight writer scoreboard (E/M/W), D-stage stall and forwarding selects.
// Optional macro HAZ_W_BYPASS_EN lets the W slot drive forwarding (select value 1).
module hazard_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       rs_D,
    input  logic [4:0]       rt_D,
    input  logic [1:0]       tuse_rs_D,
    input  logic [1:0]       tuse_rt_D,
    input  logic [4:0]       wa_D,
    input  logic [1:0]       tnew_D,
    output logic             stall,
    output logic [1:0]       fwd_rs_D,
    output logic [1:0]       fwd_rt_D,
    output logic [1:0]       fwd_rs_E,
    output logic [1:0]       fwd_rt_E,
    output logic [1:0]       fwd_rt_M,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam logic [1:0] SEL_RF = 2'd0;
    localparam logic [1:0] SEL_W  = 2'd1;
    localparam logic [1:0] SEL_M  = 2'd2;
    localparam logic [1:0] SEL_E  = 2'd3;

`ifdef HAZ_W_BYPASS_EN
    localparam logic W_BYPASS = 1'b1;
`else
    localparam logic W_BYPASS = 1'b0;
`endif

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    // Scoreboard slots
    logic [4:0]       wa_e_q, wa_e_d;
    logic [1:0]       tnew_e_q, tnew_e_d;
    logic [4:0]       rs_e_q, rs_e_d;
    logic [4:0]       rt_e_q, rt_e_d;
    logic [4:0]       wa_m_q, wa_m_d;
    logic [1:0]       tnew_m_q, tnew_m_d;
    logic [4:0]       rt_m_q, rt_m_d;
    logic [4:0]       wa_w_q, wa_w_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic stall_rs;
    logic stall_rt;

    function automatic logic src_stalls(
        input logic [4:0] src,
        input logic [1:0] tuse,
        input logic [4:0] wa_e,
        input logic [1:0] tnew_e,
        input logic [4:0] wa_m,
        input logic [1:0] tnew_m
    );
        logic hit_e;
        logic hit_m;
        hit_e = (src == wa_e) && (tuse < tnew_e);
        hit_m = (src == wa_m) && (tuse < tnew_m);
        return (src != 5'd0) && (hit_e || hit_m);
    endfunction

    // The youngest slot whose address matches owns the register: if its
    // result is not ready yet, older slots hold stale data and are ignored.
    function automatic logic [1:0] fwd_sel(
        input logic [4:0] src,
        input logic       use_e,
        input logic [4:0] wa_e,
        input logic [1:0] tnew_e,
        input logic       use_m,
        input logic [4:0] wa_m,
        input logic [1:0] tnew_m,
        input logic       use_w,
        input logic [4:0] wa_w
    );
        logic [1:0] sel;
        sel = SEL_RF;
        if (src == 5'd0) begin
            sel = SEL_RF;
        end else if (use_e && (src == wa_e)) begin
            sel = (tnew_e == 2'd0) ? SEL_E : SEL_RF;
        end else if (use_m && (src == wa_m)) begin
            sel = (tnew_m == 2'd0) ? SEL_M : SEL_RF;
        end else if (use_w && (src == wa_w)) begin
            sel = SEL_W;
        end
        return sel;
    endfunction

    always_comb begin
        stall_rs = src_stalls(rs_D, tuse_rs_D, wa_e_q, tnew_e_q, wa_m_q, tnew_m_q);
        stall_rt = src_stalls(rt_D, tuse_rt_D, wa_e_q, tnew_e_q, wa_m_q, tnew_m_q);
        stall    = 1'b0;
        fwd_rs_D = SEL_RF;
        fwd_rt_D = SEL_RF;
        fwd_rs_E = SEL_RF;
        fwd_rt_E = SEL_RF;
        fwd_rt_M = SEL_RF;
        if (!reset) begin
            stall    = stall_rs || stall_rt;
            fwd_rs_D = fwd_sel(rs_D, 1'b1, wa_e_q, tnew_e_q, 1'b1, wa_m_q, tnew_m_q,
                               W_BYPASS, wa_w_q);
            fwd_rt_D = fwd_sel(rt_D, 1'b1, wa_e_q, tnew_e_q, 1'b1, wa_m_q, tnew_m_q,
                               W_BYPASS, wa_w_q);
            fwd_rs_E = fwd_sel(rs_e_q, 1'b0, wa_e_q, tnew_e_q, 1'b1, wa_m_q, tnew_m_q,
                               W_BYPASS, wa_w_q);
            fwd_rt_E = fwd_sel(rt_e_q, 1'b0, wa_e_q, tnew_e_q, 1'b1, wa_m_q, tnew_m_q,
                               W_BYPASS, wa_w_q);
            fwd_rt_M = fwd_sel(rt_m_q, 1'b0, wa_e_q, tnew_e_q, 1'b0, wa_m_q, tnew_m_q,
                               W_BYPASS, wa_w_q);
        end
    end

    // A stall leaves the D instruction in place and sends a bubble into E.
    always_comb begin
        wa_e_d   = 5'd0;
        tnew_e_d = 2'd0;
        rs_e_d   = 5'd0;
        rt_e_d   = 5'd0;
        if (!stall) begin
            wa_e_d   = wa_D;
            tnew_e_d = tnew_D;
            rs_e_d   = rs_D;
            rt_e_d   = rt_D;
        end
        wa_m_d   = wa_e_q;
        tnew_m_d = (tnew_e_q == 2'd0) ? 2'd0 : (tnew_e_q - 2'd1);
        rt_m_d   = rt_e_q;
        wa_w_d   = wa_m_q;
        cnt_d    = cnt_q;
        if (stall && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wa_e_q   <= 5'd0;
            tnew_e_q <= 2'd0;
            rs_e_q   <= 5'd0;
            rt_e_q   <= 5'd0;
            wa_m_q   <= 5'd0;
            tnew_m_q <= 2'd0;
            rt_m_q   <= 5'd0;
            wa_w_q   <= 5'd0;
            cnt_q    <= '0;
        end else begin
            wa_e_q   <= wa_e_d;
            tnew_e_q <= tnew_e_d;
            rs_e_q   <= rs_e_d;
            rt_e_q   <= rt_e_d;
            wa_m_q   <= wa_m_d;
            tnew_m_q <= tnew_m_d;
            rt_m_q   <= rt_m_d;
            wa_w_q   <= wa_w_d;
            cnt_q    <= cnt_d;
        end
    end

    assign stall_cnt = cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: directed instruction sequences, expected outputs queued per cycle
// and checked by an independent negedge monitor. Honours HAZ_W_BYPASS_EN for W-select values.
module tb_hazard_ctrl;

    localparam int CNT_W = 3;
    localparam int EXP_W = 11 + CNT_W;

`ifdef HAZ_W_BYPASS_EN
    localparam int WSEL = 1;
`else
    localparam int WSEL = 0;
`endif

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic [4:0]       rs_D = 5'd0;
    logic [4:0]       rt_D = 5'd0;
    logic [1:0]       tuse_rs_D = 2'd3;
    logic [1:0]       tuse_rt_D = 2'd3;
    logic [4:0]       wa_D = 5'd0;
    logic [1:0]       tnew_D = 2'd0;
    logic             stall;
    logic [1:0]       fwd_rs_D;
    logic [1:0]       fwd_rt_D;
    logic [1:0]       fwd_rs_E;
    logic [1:0]       fwd_rt_E;
    logic [1:0]       fwd_rt_M;
    logic [CNT_W-1:0] stall_cnt;

    logic [EXP_W-1:0] exp_q[$];
    string            name_q[$];
    int               n_cmp = 0;
    int               n_err = 0;

    hazard_ctrl #(.CNT_W(CNT_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .rs_D      (rs_D),
        .rt_D      (rt_D),
        .tuse_rs_D (tuse_rs_D),
        .tuse_rt_D (tuse_rt_D),
        .wa_D      (wa_D),
        .tnew_D    (tnew_D),
        .stall     (stall),
        .fwd_rs_D  (fwd_rs_D),
        .fwd_rt_D  (fwd_rt_D),
        .fwd_rs_E  (fwd_rs_E),
        .fwd_rt_E  (fwd_rt_E),
        .fwd_rt_M  (fwd_rt_M),
        .stall_cnt (stall_cnt)
    );

    // Clock and watchdog
    always #5 clk = ~clk;

    initial begin
        #20000;
        $display("FAIL watchdog: run did not finish within 20000 time units");
        $fatal(1, "watchdog expired");
    end

    function automatic string fmt(input logic [EXP_W-1:0] v);
        return $sformatf("stall=%0d rsD=%0d rtD=%0d rsE=%0d rtE=%0d rtM=%0d cnt=%0d",
                         v[EXP_W-1], v[CNT_W+8 +: 2], v[CNT_W+6 +: 2], v[CNT_W+4 +: 2],
                         v[CNT_W+2 +: 2], v[CNT_W +: 2], v[0 +: CNT_W]);
    endfunction

    // Driver: one call per clock cycle; inputs change 1 time unit after the rising edge.
    task automatic step(input int rst, input int rs, input int rt, input int tur, input int tut,
                        input int wa, input int tn, input int e_st, input int e_rsd,
                        input int e_rtd, input int e_rse, input int e_rte, input int e_rtm,
                        input int e_cnt, input string nm);
        @(posedge clk);
        #1;
        reset     = 1'(rst);
        rs_D      = 5'(rs);
        rt_D      = 5'(rt);
        tuse_rs_D = 2'(tur);
        tuse_rt_D = 2'(tut);
        wa_D      = 5'(wa);
        tnew_D    = 2'(tn);
        exp_q.push_back({1'(e_st), 2'(e_rsd), 2'(e_rtd), 2'(e_rse), 2'(e_rte), 2'(e_rtm),
                         CNT_W'(e_cnt)});
        name_q.push_back(nm);
    endtask

    task automatic nop(input int e_rse, input int e_rte, input int e_rtm, input int e_cnt,
                       input string nm);
        step(0, 0, 0, 3, 3, 0, 0, 0, 0, 0, e_rse, e_rte, e_rtm, e_cnt, nm);
    endtask

    // Scoreboard monitor: compares on the falling edge, away from the update edge.
    initial begin
        logic [EXP_W-1:0] exp_v;
        logic [EXP_W-1:0] act_v;
        string            nm;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                exp_v = exp_q.pop_front();
                nm    = name_q.pop_front();
                act_v = {stall, fwd_rs_D, fwd_rt_D, fwd_rs_E, fwd_rt_E, fwd_rt_M, stall_cnt};
                n_cmp++;
                if (act_v !== exp_v) begin
                    n_err++;
                    $display("FAIL %s: got [%s] expected [%s]", nm, fmt(act_v), fmt(exp_v));
                end
            end
        end
    end

    initial begin
        // reset: outputs forced low even with a hazardous-looking D instruction
        step(1, 5, 5, 0, 0, 5, 2,  0, 0, 0, 0, 0, 0, 0, "rst_hold0");
        step(1, 0, 0, 3, 3, 0, 0,  0, 0, 0, 0, 0, 0, 0, "rst_hold1");

        // addu $3 ; subu $6,$3,$4 : Tuse 1 vs Tnew 1 needs no stall, E takes M result
        step(0, 1, 2, 1, 1, 3, 1,  0, 0, 0, 0, 0, 0, 0, "addu_d");
        step(0, 3, 4, 1, 1, 6, 1,  0, 0, 0, 0, 0, 0, 0, "subu_d");
        nop(2, 0, 0, 0, "subu_e_fwd_m");
        nop(0, 0, 0, 0, "c1_flush0");
        nop(0, 0, 0, 0, "c1_flush1");

        // lw $5 ; beq $5 (Tuse 0): two stalls then W bypass
        step(0, 29, 0, 1, 3, 5, 2,  0, 0, 0, 0, 0, 0, 0, "lw5_d");
        step(0, 5, 6, 0, 0, 0, 0,   1, 0, 0, 0, 0, 0, 0, "beq_stall1");
        step(0, 5, 6, 0, 0, 0, 0,   1, 0, 0, 0, 0, 0, 1, "beq_stall2");
        step(0, 5, 6, 0, 0, 0, 0,   0, WSEL, 0, 0, 0, 0, 2, "beq_fwd_w");
        nop(0, 0, 0, 2, "c2_flush");

        // jal ; jr $31
        step(0, 0, 0, 3, 3, 31, 0,  0, 0, 0, 0, 0, 0, 2, "jal_d");
        step(0, 31, 0, 0, 3, 0, 0,  0, 3, 0, 0, 0, 0, 2, "jr_fwd_e");
        nop(2, 0, 0, 2, "jr_e_fwd_m");
        nop(0, 0, 0, 2, "c3_flush");

        // writer to $0 then reader of $0
        step(0, 1, 2, 1, 1, 0, 2,   0, 0, 0, 0, 0, 0, 2, "wr_r0");
        step(0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 2, "rd_r0");
        nop(0, 0, 0, 2, "c4_flush");

        // lw $4 ; sw $4 (Tuse_rt 2)
        step(0, 29, 0, 1, 3, 4, 2,  0, 0, 0, 0, 0, 0, 2, "lw4_d");
        step(0, 29, 4, 1, 2, 0, 0,  0, 0, 0, 0, 0, 0, 2, "sw_d");
        nop(0, 0, 0, 2, "sw_e");
        nop(0, 0, WSEL, 2, "sw_m_fwd_w");

        // addu $7 ; gap ; or $8,$7,$7
        step(0, 0, 0, 3, 3, 7, 1,   0, 0, 0, 0, 0, 0, 2, "addu7_d");
        nop(0, 0, 0, 2, "c6_gap");
        step(0, 7, 7, 0, 0, 8, 1,   0, 2, 2, 0, 0, 0, 2, "or_fwd_m");
        nop(WSEL, WSEL, 0, 2, "or_e_fwd_w");
        nop(0, 0, 0, 2, "c6_flush0");
        nop(0, 0, 0, 2, "c6_flush1");

        // addu $9 ; beq $9 (Tuse 0 vs Tnew 1): one stall
        step(0, 1, 2, 1, 1, 9, 1,   0, 0, 0, 0, 0, 0, 2, "addu9_d");
        step(0, 9, 0, 0, 0, 0, 0,   1, 0, 0, 0, 0, 0, 2, "beq9_stall");
        step(0, 9, 0, 0, 0, 0, 0,   0, 2, 0, 0, 0, 0, 3, "beq9_fwd_m");
        nop(WSEL, 0, 0, 3, "beq9_e_fwd_w");

        // E and M both writing $10: younger slot owns the register
        step(0, 0, 0, 3, 3, 10, 1,  0, 0, 0, 0, 0, 0, 3, "addu10_d");
        step(0, 0, 0, 3, 3, 10, 2,  0, 0, 0, 0, 0, 0, 3, "lw10_d");
        step(0, 10, 0, 1, 3, 0, 0,  1, 0, 0, 0, 0, 0, 3, "rd10_e_governs");
        step(0, 10, 0, 1, 3, 0, 0,  0, 0, 0, 0, 0, 0, 4, "rd10_m_governs");
        nop(WSEL, 0, 0, 4, "rd10_e_fwd_w");

        // counter saturation at 7 (CNT_W = 3)
        step(0, 29, 0, 1, 3, 5, 2,  0, 0, 0, 0, 0, 0, 4, "sat_lw_a");
        step(0, 5, 0, 0, 3, 0, 0,   1, 0, 0, 0, 0, 0, 4, "sat_stall_a1");
        step(0, 5, 0, 0, 3, 0, 0,   1, 0, 0, 0, 0, 0, 5, "sat_stall_a2");
        step(0, 5, 0, 0, 3, 0, 0,   0, WSEL, 0, 0, 0, 0, 6, "sat_fwd_a");
        nop(0, 0, 0, 6, "sat_gap_a");
        step(0, 29, 0, 1, 3, 5, 2,  0, 0, 0, 0, 0, 0, 6, "sat_lw_b");
        step(0, 5, 0, 0, 3, 0, 0,   1, 0, 0, 0, 0, 0, 6, "sat_stall_b1");
        step(0, 5, 0, 0, 3, 0, 0,   1, 0, 0, 0, 0, 0, 7, "sat_stall_b2");
        step(0, 5, 0, 0, 3, 0, 0,   0, WSEL, 0, 0, 0, 0, 7, "sat_hold");
        nop(0, 0, 0, 7, "sat_gap_b");

        // pending load-use hazard discarded by a mid-run reset pulse
        step(0, 29, 0, 1, 3, 5, 2,  0, 0, 0, 0, 0, 0, 7, "lw5_pre_rst");
        step(1, 5, 0, 0, 3, 0, 0,   0, 0, 0, 0, 0, 0, 7, "rst_mid");
        step(0, 5, 0, 0, 3, 0, 0,   0, 0, 0, 0, 0, 0, 0, "post_rst_no_stall");
        nop(0, 0, 0, 0, "post_rst_idle");

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) begin
            @(negedge clk);
        end
        #1;
        if (exp_q.size() > 0) begin
            n_err++;
            $display("FAIL drain: %0d expected entries never compared, required 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
